// File: rtl/divider.sv
// rtl/divider.sv - unsigned multi-cycle restoring divider, one quotient bit per clock
// Operands are latched on vld in IDLE; result appears with a one-cycle ack pulse XLEN edges later.
module divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            vld,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            ack,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] prem;

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] prem_next;
  logic [XLEN-1:0] dvd_next;

  // dvd doubles as the quotient register: dividend bits shift out the top while
  // quotient bits shift in at the bottom.
  always_comb begin
    shifted   = {prem, dvd[XLEN-1]};
    diff      = shifted - {1'b0, dvs};
    prem_next = shifted[XLEN-1:0];
    dvd_next  = {dvd[XLEN-2:0], 1'b0};
    if (!diff[XLEN]) begin
      prem_next = diff[XLEN-1:0];
      dvd_next  = {dvd[XLEN-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      prem  <= '0;
      ack   <= 1'b0;
      quo   <= '0;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          if (vld) begin
            dvd   <= a;
            dvs   <= b;
            prem  <= '0;
            cnt   <= CNT_INIT;
            state <= BUSY;
          end
        end
        BUSY: begin
          dvd  <= dvd_next;
          prem <= prem_next;
          cnt  <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            quo   <= dvd_next;
            rem   <= prem_next;
            ack   <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          ack   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - scoreboard bench for divider against an arithmetic reference model
module tb_divider;
  localparam int XLEN = 32;
  localparam int LAT  = XLEN;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            vld = 1'b0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            ack;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] exp_r[$];
  int              exp_c[$];
  logic [XLEN-1:0] last_q = '0;
  logic [XLEN-1:0] last_r = '0;

  divider #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .a(a), .b(b),
    .ack(ack), .quo(quo), .rem(rem)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every ack, otherwise checks that the outputs hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_ack: actual ack=1 required ack=0 (no request pending) at cycle %0d", cyc);
        end else begin
          logic [XLEN-1:0] eq, er;
          int ec;
          eq = exp_q.pop_front();
          er = exp_r.pop_front();
          ec = exp_c.pop_front();
          check("quo", quo, eq);
          check("rem", rem, er);
          check("ack_latency_cycle", cyc, ec);
          last_q = eq;
          last_r = er;
        end
      end else begin
        check("quo_hold", quo, last_q);
        check("rem_hold", rem, last_r);
      end
    end
  end

  function automatic logic [XLEN-1:0] ref_quo(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    return (y == 0) ? {XLEN{1'b1}} : x / y;
  endfunction

  function automatic logic [XLEN-1:0] ref_rem(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    return (y == 0) ? x : x % y;
  endfunction

  // Called at a negedge with the DUT idle; returns at the following negedge.
  task automatic issue(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    vld = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    exp_q.push_back(ref_quo(x, y));
    exp_r.push_back(ref_rem(x, y));
    exp_c.push_back(cyc + LAT);
    @(negedge clk);
    vld = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_ack();
    int n = 0;
    while (!ack && n < 3 * LAT) begin
      @(negedge clk);
      n++;
    end
    if (!ack) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: actual no ack after %0d cycles required ack within %0d", n, LAT);
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    issue(x, y);
    wait_ack();
  endtask

  initial begin
    #12;
    check("reset_ack", ack, 0);
    check("reset_quo", quo, 0);
    check("reset_rem", rem, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);

    run(10, 7);
    run(100, 100);
    run(100, 7);
    run(100, 0);
    run(70, 150);
    run(32'hFFFF_FFFF, 1);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(32'h8000_0000, 0);
    run(0, 5);

    // vld while BUSY must be ignored; an extra ack would hit the empty scoreboard.
    issue(10, 7);
    repeat (5) @(negedge clk);
    vld = 1'b1;
    a = 5;
    b = 1;
    @(negedge clk);
    vld = 1'b0;
    wait_ack();

    // Back-to-back: each request issued the cycle after the previous ack.
    for (int i = 0; i < 4; i++) run($urandom, $urandom_range(1, 1000));

    for (int i = 0; i < 24; i++) begin
      logic [XLEN-1:0] x, y;
      x = $urandom;
      case (i % 4)
        0: y = $urandom;
        1: y = $urandom_range(1, 255);
        2: y = 0;
        default: y = x + $urandom_range(1, 100);
      endcase
      run(x, y);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset mid-BUSY: outputs clear without a clock edge, the aborted op never acks.
    issue($urandom, $urandom_range(1, 50));
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("async_reset_ack", ack, 0);
    check("async_reset_quo", quo, 0);
    check("async_reset_rem", rem, 0);
    exp_q.delete();
    exp_r.delete();
    exp_c.delete();
    last_q = '0;
    last_r = '0;
    @(negedge clk);
    vld = 1'b1;
    a = 9;
    b = 3;
    @(negedge clk);
    vld = 1'b0;
    rst_n = 1'b0;
    repeat (2 * LAT) @(negedge clk);
    run(1000, 33);
    run(10, 7);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual simulation still running required completion");
    $fatal(1);
  end
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL provide parameter XLEN, default 32: operand and result width in bits.
REQ-002 SHALL provide port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1 bit: asynchronous, active-high reset, despite the _n suffix (1 = reset).
REQ-004 SHALL provide port vld, input, 1 bit: start request; a and b are sampled with it.
REQ-005 SHALL provide port a, input, XLEN bits: unsigned dividend.
REQ-006 SHALL provide port b, input, XLEN bits: unsigned divisor.
REQ-007 SHALL provide port ack, output, 1 bit: one-cycle completion pulse; quo and rem are valid while it is high.
REQ-008 SHALL provide port quo, output, XLEN bits: unsigned quotient.
REQ-009 SHALL provide port rem, output, XLEN bits: unsigned remainder.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, BUSY and DONE.
REQ-011 In IDLE, a rising edge with vld=1 SHALL:
- latch a and b into internal registers;
- clear the partial remainder;
- load the iteration counter with XLEN;
- move to BUSY.
REQ-012 In IDLE, vld=0 SHALL leave the FSM in IDLE.
REQ-013 In BUSY, each rising edge SHALL perform one restoring-division step:
- shift {partial remainder, dividend} left by one;
- trial-subtract the divisor from the partial remainder, computed at XLEN+1 bits;
- if the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set the LSB to 0.
REQ-014 After exactly XLEN BUSY steps the FSM SHALL move to DONE, and quo/rem SHALL take the final quotient and remainder on that same edge.
REQ-015 Latency: ack SHALL be high in the single cycle beginning XLEN rising edges after the edge that sampled vld (XLEN=32: 32 edges).
REQ-016 In DONE, ack SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE unconditionally.
REQ-017 ack SHALL be 0 in IDLE and BUSY.
REQ-018 quo and rem SHALL hold their last result after ack falls, until the next completion or reset.
REQ-019 vld SHALL be ignored in BUSY and DONE; no queuing, and the in-flight operation is unaffected.
REQ-020 Changes on a/b outside the sampling edge SHALL NOT affect the result.
REQ-021 Divide by zero (b=0) SHALL produce quo = all ones (2^XLEN-1) and rem = a, with the normal latency and ack pulse.
REQ-022 A dividend smaller than the divisor SHALL produce quo=0 and rem=a.
REQ-023 All arithmetic SHALL be unsigned, with no overflow flag.
REQ-024 The design SHALL be fully synchronous except for reset, with no combinational path from inputs to outputs.

Reset
REQ-025 Asserting rst_n=1 SHALL immediately, without a clock edge:
- force the FSM to IDLE;
- set ack=0, quo=0 and rem=0;
- clear the counter and internal registers.
REQ-026 Reset asserted mid-operation SHALL abort the division, with no ack produced for it.
REQ-027 After reset deasserts, the first rising edge with vld=1 SHALL start a new operation normally.
REQ-028 vld asserted while reset is high SHALL be ignored.

Verification
REQ-029 Scenario 1: vld pulse with a=10, b=7 -> ack one cycle, 32 edges later; quo=1, rem=3.
REQ-030 Scenario 2: a=100, b=100 -> quo=1, rem=0; a=100, b=7 -> quo=14, rem=2.
REQ-031 Scenario 3: a=100, b=0 -> quo=4294967295, rem=100; a=70, b=150 -> quo=0, rem=70.
REQ-032 Scenario 4: vld re-pulsed with a=5, b=1 while BUSY on a=10, b=7 -> ignored; the result is quo=1, rem=3, with ack only once.
REQ-033 Scenario 5: reset asserted mid-BUSY -> ack, quo and rem go to 0 asynchronously, with no ack afterward; a new request after reset is computed correctly.
REQ-034 Scenario 6: back-to-back requests issued one cycle after ack -> each gets an ack pulse, and quo/rem hold their value between pulses.
